store_write_buffer: RTL

- Posted-store FIFO on the data side, between the MMU's uncached store path and the AXI write channels (AW/W/B).
- The CPU store path pushes a word-aligned store and continues without waiting for the AXI response.
- A drain FSM retires entries one at a time as single-beat AXI writes.
- An address probe lets the load path stall on read-after-write hazards against buffered stores.

---
 rtl/store_write_buffer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// Posted-store FIFO draining one entry at a time as single-beat AXI writes.
// Includes an address probe so loads can stall on read-after-write hazards.
module store_write_buffer #(
    parameter int          DEPTH  = 4,
    parameter logic [3:0]  AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_strb,
    output logic        st_ready,
    input  logic [31:0] probe_addr,
    output logic        probe_hit,
    output logic        empty,
    output logic        err,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [3:0]       strb_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    state_t           state, state_n;

    logic        push, pop;
    logic        awvalid_n, wvalid_n, bready_n, err_n;
    logic [31:0] awaddr_n, wdata_n;
    logic [3:0]  wstrb_n;
    logic        unused_bits;

    assign unused_bits = ^{bid, st_addr[1:0], probe_addr[1:0]};

    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign awlen   = 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wlast   = 1'b1;

    assign st_ready = (count != FULL);
    assign push     = st_valid && st_ready;
    assign empty    = (count == '0) && (state == IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= st_addr[31:2];
            data_mem[wr_ptr] <= st_wdata;
            strb_mem[wr_ptr] <= st_strb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            state   <= IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            err     <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            state   <= state_n;
            awvalid <= awvalid_n;
            wvalid  <= wvalid_n;
            bready  <= bready_n;
            err     <= err_n;
            awaddr  <= awaddr_n;
            wdata   <= wdata_n;
            wstrb   <= wstrb_n;
        end
    end

    always_comb begin
        state_n   = state;
        awvalid_n = awvalid;
        wvalid_n  = wvalid;
        bready_n  = bready;
        err_n     = err;
        awaddr_n  = awaddr;
        wdata_n   = wdata;
        wstrb_n   = wstrb;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    awaddr_n  = {addr_mem[rd_ptr], 2'b00};
                    wdata_n   = data_mem[rd_ptr];
                    wstrb_n   = strb_mem[rd_ptr];
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    state_n   = SEND;
                end
            end
            SEND: begin
                // Each valid clears on its own handshake; the pair done means both low.
                awvalid_n = awvalid && !awready;
                wvalid_n  = wvalid && !wready;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n = 1'b1;
                    state_n  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bvalid) begin
                    bready_n = 1'b0;
                    pop      = 1'b1;
                    if (bresp != 2'b00) err_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The draining entry stays counted until its pop, so it is still probed.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset    = '0;
        probe_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if (({1'b0, offset} < count) && (addr_mem[i] == probe_addr[31:2]))
                probe_hit = 1'b1;
        end
    end

endmodule
